// File: rtl/frogger_pkg.sv
// Shared definitions for the frog game controller.
//   game_state_t : controller FSM state encoding
//   LIVES_W      : width of the lives counter
//   LEVEL_W      : width of the level counter
//   SCORE_W      : width of the crossing score
package frogger_pkg;

  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 3;
  localparam int SCORE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    PLAY  = 3'd2,
    HIT   = 3'd3,
    WIN   = 3'd4,
    OVER  = 3'd5
  } game_state_t;

endpackage

// File: rtl/lane_tick_gen.sv
// Lane-tick generator: emits a one-cycle registered pulse every
// P = TICK_BASE*(MAX_LEVEL+1-level) cycles while the game is in PLAY.
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high
//   enable    : high when the NEXT cycle is a PLAY cycle
//   level     : current level (stable throughout PLAY)
//   lane_tick : registered pulse, high on PLAY cycles P, 2P, 3P, ...
module lane_tick_gen
  import frogger_pkg::*;
#(
  parameter int TICK_BASE = 4,
  parameter int MAX_LEVEL = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] level,
  output logic               lane_tick
);

  localparam int PMAX  = TICK_BASE * (MAX_LEVEL + 1);
  localparam int CNT_W = (PMAX > 1) ? $clog2(PMAX) : 1;

  function automatic logic [CNT_W:0] period_of(input logic [LEVEL_W-1:0] lvl);
    int p;
    p = TICK_BASE * (MAX_LEVEL + 1 - int'(lvl));
    return (CNT_W+1)'(p);
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   period;

  assign period = period_of(level);

  // cnt holds (PLAY cycle index mod P) for the current cycle and is 0
  // outside PLAY. Because enable looks one cycle ahead, the tick register
  // is loaded for the upcoming cycle, so even P=1 ticks on the first
  // PLAY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      lane_tick <= 1'b0;
    end else if (!enable) begin
      cnt       <= '0;
      lane_tick <= 1'b0;
    end else if ({1'b0, cnt} == period - (CNT_W+1)'(1)) begin
      cnt       <= '0;
      lane_tick <= 1'b1;
    end else begin
      cnt       <= cnt + CNT_W'(1);
      lane_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/frog_game_ctrl.sv
// Frog game controller: sequences spawn / play / hit / win / game-over,
// tracks lives, level and score, and paces the car lanes.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle start pulse (honoured in IDLE and OVER)
//   hit          : any frog cell reports game over (PLAY only)
//   frog_at_top  : frog reached the top row (PLAY only)
//   cells_reset  : clear to all frog cells (IDLE, HIT, WIN, OVER)
//   spawn        : seed pulse into the bottom-centre cell (SPAWN)
//   lane_tick    : one-cycle pulse advancing the car lanes
//   playing      : high in PLAY
//   lives, level, score : game status
module frog_game_ctrl
  import frogger_pkg::*;
#(
  parameter int TICK_BASE   = 4,
  parameter int MAX_LEVEL   = 7,
  parameter int HOLD_CYCLES = 8,
  parameter int LIVES_INIT  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hit,
  input  logic               frog_at_top,
  output logic               cells_reset,
  output logic               spawn,
  output logic               lane_tick,
  output logic               playing,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic [SCORE_W-1:0] score
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  game_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              play_next;
  logic              hold_done;

  assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

  // Next cycle is PLAY: leaving SPAWN, or staying in PLAY with no event.
  assign play_next = (state == SPAWN) ||
                     ((state == PLAY) && !hit && !frog_at_top);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lives    <= '0;
      level    <= '0;
      score    <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state <= SPAWN;
            lives <= LIVES_W'(LIVES_INIT);
            level <= '0;
            score <= '0;
          end
        end
        SPAWN: state <= PLAY;
        PLAY: begin
          hold_cnt <= '0;
          if (hit) begin
            state <= HIT;
            lives <= (lives != '0) ? lives - LIVES_W'(1) : lives;
          end else if (frog_at_top) begin
            state <= WIN;
            score <= (score != '1) ? score + SCORE_W'(1) : score;
            level <= (level != LEVEL_W'(MAX_LEVEL)) ? level + LEVEL_W'(1) : level;
          end
        end
        HIT, WIN: begin
          if (hold_done) begin
            hold_cnt <= '0;
            state    <= ((state == HIT) && (lives == '0)) ? OVER : SPAWN;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cells_reset = (state == IDLE) || (state == HIT) ||
                       (state == WIN)  || (state == OVER);
  assign spawn       = (state == SPAWN);
  assign playing     = (state == PLAY);

  lane_tick_gen #(
    .TICK_BASE (TICK_BASE),
    .MAX_LEVEL (MAX_LEVEL)
  ) u_lane_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .enable    (play_next),
    .level     (level),
    .lane_tick (lane_tick)
  );

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl with TICK_BASE=2, MAX_LEVEL=3,
// HOLD_CYCLES=2, LIVES_INIT=3 (tick period 8 at level 0, 6 at level 1).
module tb_frog_game_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, hit, frog_at_top;
  logic       cells_reset, spawn, lane_tick, playing;
  logic [1:0] lives;
  logic [2:0] level;
  logic [7:0] score;

  int n_cmp = 0;
  int n_mis = 0;

  frog_game_ctrl #(
    .TICK_BASE   (2),
    .MAX_LEVEL   (3),
    .HOLD_CYCLES (2),
    .LIVES_INIT  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .hit         (hit),
    .frog_at_top (frog_at_top),
    .cells_reset (cells_reset),
    .spawn       (spawn),
    .lane_tick   (lane_tick),
    .playing     (playing),
    .lives       (lives),
    .level       (level),
    .score       (score)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic cr, input logic sp,
                              input logic pl, input logic [1:0] lv,
                              input logic [2:0] lvl, input logic [7:0] sc);
    check_eq({tag, ".cells_reset"}, 32'(cells_reset), 32'(cr));
    check_eq({tag, ".spawn"},       32'(spawn),       32'(sp));
    check_eq({tag, ".playing"},     32'(playing),     32'(pl));
    check_eq({tag, ".lives"},       32'(lives),       32'(lv));
    check_eq({tag, ".level"},       32'(level),       32'(lvl));
    check_eq({tag, ".score"},       32'(score),       32'(sc));
  endtask

  // Checks lane_tick over n PLAY cycles starting at PLAY cycle 1; leaves
  // the bench on PLAY cycle n+1.
  task automatic check_ticks(input string tag, input int n, input int period);
    for (int k = 1; k <= n; k++) begin
      check_eq(tag, 32'(lane_tick), 32'((k % period) == 0));
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; hit = 1'b0; frog_at_top = 1'b0;
    step(); step();
    check_status("reset", 1, 0, 0, 0, 0, 0);
    check_eq("reset.lane_tick", 32'(lane_tick), 32'd0);

    // Start: one SPAWN cycle, then PLAY
    reset = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check_status("spawn1", 0, 1, 0, 3, 0, 0);
    step();
    check_status("play1", 0, 0, 1, 3, 0, 0);

    // Level 0: ticks on PLAY cycles 8, 16, 24
    check_ticks("tick_l0", 24, 8);
    check_eq("play25.playing", 32'(playing), 32'd1);

    // Win: two hold cycles, then SPAWN
    frog_at_top = 1'b1;
    step();
    frog_at_top = 1'b0;
    check_status("win1", 1, 0, 0, 3, 1, 1);
    check_eq("win1.lane_tick", 32'(lane_tick), 32'd0);
    step();
    check_status("win2", 1, 0, 0, 3, 1, 1);
    step();
    check_status("spawn2", 0, 1, 0, 3, 1, 1);
    step();
    check_ticks("tick_l1", 12, 6);

    // Hit and frog_at_top together: hit wins
    hit = 1'b1; frog_at_top = 1'b1;
    step();
    hit = 1'b0; frog_at_top = 1'b0;
    check_status("hit1", 1, 0, 0, 2, 1, 1);
    step();
    step();
    check_status("spawn3", 0, 1, 0, 2, 1, 1);
    step();
    hit = 1'b1;
    step();
    hit = 1'b0;
    check_status("hit2", 1, 0, 0, 1, 1, 1);
    step(); step(); step();
    check_eq("play_after_hit2", 32'(playing), 32'd1);
    hit = 1'b1;
    step();
    hit = 1'b0;
    check_status("hit3", 1, 0, 0, 0, 1, 1);
    step(); step();
    check_status("over", 1, 0, 0, 0, 1, 1);
    step(); step();
    check_status("over_hold", 1, 0, 0, 0, 1, 1);

    // Restart from OVER; hit during SPAWN is ignored
    start = 1'b1; hit = 1'b1;
    step();
    start = 1'b0;
    check_status("restart_spawn", 0, 1, 0, 3, 0, 0);
    step();
    hit = 1'b0;
    check_status("restart_play", 0, 0, 1, 3, 0, 0);

    // Reset in the middle of a WIN hold
    frog_at_top = 1'b1;
    step();
    frog_at_top = 1'b0;
    check_status("win_pre_reset", 1, 0, 0, 3, 1, 1);
    reset = 1'b1;
    step();
    check_status("mid_win_reset", 1, 0, 0, 0, 0, 0);
    check_eq("mid_win_reset.lane_tick", 32'(lane_tick), 32'd0);
    reset = 1'b0;
    step();
    check_status("idle_after_reset", 1, 0, 0, 0, 0, 0);

    // Counters cleared: fresh game ticks again on PLAY cycle 8
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_ticks("tick_after_reset", 8, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
